datapath_gen: RTL and testbench
===============================

Name: datapath_gen

Overview:
Parametrised successor to the single-cycle 16x16 datapath. Bundles data memory, register file, writeback mux and ALU behind a Start/Busy/Done command handshake, with a small FSM that sequences LOAD, STORE and ALU operations over multiple cycles. It also registers the operands and the result. Sits directly under the controller FSM, which issues one command at a time.

Parameters:
DATA_W, 16, datapath word width (>= 4)
RF_DEPTH, 16, number of registers (power of 2); RF_AW = clog2(RF_DEPTH)
DMEM_DEPTH, 256, data memory words (power of 2); DM_AW = clog2(DMEM_DEPTH)

Ports:
Clk  in  1  clock; all state updates on rising edge
Reset  in  1  synchronous, active-high reset
Start  in  1  command strobe; sampled only in IDLE
Op  in  2  command: 0 LOAD, 1 STORE, 2 ALU, 3 NOP
ALUSelect  in  3  ALU function for ALU commands
DAddr  in  DM_AW  data memory address
WriteAddr  in  RF_AW  RF destination (LOAD/ALU)
ReadAddrA  in  RF_AW  RF source A (ALU; store data for STORE)
ReadAddrB  in  RF_AW  RF source B (ALU)
Busy  out  1  high from the cycle after accept until Done
Done  out  1  one-cycle completion pulse
ALUinA  out  DATA_W  registered operand A
ALUinB  out  DATA_W  registered operand B
ALUout  out  DATA_W  registered ALU result
Zero, Carry, Overflow  out  1 each  registered status flags (see Optional Feature)

Behaviour:
- One clock, Clk. Reset is synchronous and active-high.
- Reset: FSM to IDLE; Busy, Done, ALUinA, ALUinB, ALUout and flags all 0; every RF entry cleared to 0. Data memory contents are not reset.
- Reset asserted in any state aborts the command at that edge: no RF or memory write occurs on that edge.
- States and transitions:
  - IDLE: when Start=1, latch Op, ALUSelect, DAddr and all RF addresses into command registers, then go to EXEC. Otherwise stay in IDLE.
  - EXEC (Busy=1): latch ALUinA=RF[A] and ALUinB=RF[B].
    - ALU: ALUout <= f(A,B); RF[WriteAddr] <= result on the same edge; go to DONE.
    - STORE: D[DAddr] <= RF[A]; go to DONE.
    - LOAD: issue the memory read; go to MEMRD.
    - NOP: go to DONE with no writes.
  - MEMRD (Busy=1): RF[WriteAddr] <= D[DAddr], using the 1-cycle synchronous read data; go to DONE.
  - DONE: Done=1, Busy=0; go to IDLE unconditionally. Start is ignored here.
- Latency, counted as edges from the accepting edge to Done high: ALU, STORE and NOP = 2; LOAD = 3.
- Start while not in IDLE is ignored. Input ports may change freely after the accept edge.
- ALU function by ALUSelect:
  - 0: pass A
  - 1: A+B
  - 2: A-B
  - 3: A&B
  - 4: A|B
  - 5: A^B
  - 6: ~A
  - 7: 0
- Arithmetic is modulo 2^DATA_W.
- RF reads are combinational. RF write-then-read of the same register is visible to the next command.
- An address at the top of the range (DAddr = DMEM_DEPTH-1, register RF_DEPTH-1) is valid. There is no wrap logic, because addresses are exact width.
- LOAD/STORE leave ALUout and the flags unchanged.

Optional Feature:
Macro DATAPATH_GEN_FLAGS_EN.
- Defined: on each ALU command, Zero/Carry/Overflow update on the same edge as ALUout.
  - Zero = (result == 0).
  - Carry = carry-out for ADD, borrow (A < B unsigned) for SUB, 0 for all other functions.
  - Overflow = signed overflow for ADD/SUB, 0 otherwise.
- Undefined: Zero, Carry and Overflow are tied to 0 and no flag logic is synthesised.

Test Plan:
- Reset, then ALU op6 (~A) with A=R0, dest R1 -> R1 = 0xFFFF. Done rises 2 edges after accept; Busy high exactly 1 cycle.
- ALU op1 with R1+R1, dest R2 -> ALUout = 0xFFFE. With FLAGS_EN: Carry=1, Overflow=0, Zero=0.
- ALU op2 with R1-R1, dest R3 -> ALUout = 0x0000, Zero=1, Carry=0. Then op2 with R0-R1 -> 0x0001, Carry=1.
- STORE R2 to D[9], then LOAD D[9] into R5, then ALU pass R5 -> ALUout = 0xFFFE. LOAD Done comes 3 edges after accept.
- Start held high throughout a LOAD -> exactly one command executes; the next accept occurs only in IDLE after DONE.
- Reset asserted in MEMRD of a LOAD into R6 -> R6 = 0, Busy = Done = 0 next cycle, FSM in IDLE.

Source files
------------

// File: rtl/datapath_gen_if.sv
// Command/result bundle between the controller FSM and datapath_gen.
// Latency: none (wires only).
// Backpressure: Start is honoured only while the datapath is idle; Busy/Done report progress.
interface datapath_gen_if #(
    parameter int DATA_W     = 16,
    parameter int RF_DEPTH   = 16,
    parameter int DMEM_DEPTH = 256
);
    localparam int RF_AW = $clog2(RF_DEPTH);
    localparam int DM_AW = $clog2(DMEM_DEPTH);

    logic              Start;
    logic [1:0]        Op;
    logic [2:0]        ALUSelect;
    logic [DM_AW-1:0]  DAddr;
    logic [RF_AW-1:0]  WriteAddr;
    logic [RF_AW-1:0]  ReadAddrA;
    logic [RF_AW-1:0]  ReadAddrB;
    logic              Busy;
    logic              Done;
    logic [DATA_W-1:0] ALUinA;
    logic [DATA_W-1:0] ALUinB;
    logic [DATA_W-1:0] ALUout;
    logic              Zero;
    logic              Carry;
    logic              Overflow;

    modport master (
        output Start, Op, ALUSelect, DAddr, WriteAddr, ReadAddrA, ReadAddrB,
        input  Busy, Done, ALUinA, ALUinB, ALUout, Zero, Carry, Overflow
    );

    modport slave (
        input  Start, Op, ALUSelect, DAddr, WriteAddr, ReadAddrA, ReadAddrB,
        output Busy, Done, ALUinA, ALUinB, ALUout, Zero, Carry, Overflow
    );
endinterface

// File: rtl/datapath_gen.sv
// Multi-cycle datapath: register file, data memory and ALU sequenced by IDLE/EXEC/MEMRD/DONE.
// Latency: ALU/STORE/NOP finish 2 edges after accept, LOAD 3 (Done is a 1-cycle pulse).
// Backpressure: one command at a time; Start is ignored unless idle. Flags need DATAPATH_GEN_FLAGS_EN.
module datapath_gen #(
    parameter int DATA_W     = 16,
    parameter int RF_DEPTH   = 16,
    parameter int DMEM_DEPTH = 256
) (
    input  logic            Clk,
    input  logic            Reset,
    datapath_gen_if.slave   bus
);
    localparam int RF_AW = $clog2(RF_DEPTH);
    localparam int DM_AW = $clog2(DMEM_DEPTH);

    localparam logic [1:0] OP_LOAD  = 2'd0;
    localparam logic [1:0] OP_STORE = 2'd1;
    localparam logic [1:0] OP_ALU   = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_MEMRD = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [2:0]          sel_q, sel_d;
    logic [DM_AW-1:0]    daddr_q, daddr_d;
    logic [RF_AW-1:0]    waddr_q, waddr_d;
    logic [RF_AW-1:0]    raddr_a_q, raddr_a_d;
    logic [RF_AW-1:0]    raddr_b_q, raddr_b_d;
    logic [DATA_W-1:0]   alu_in_a_q, alu_in_a_d;
    logic [DATA_W-1:0]   alu_in_b_q, alu_in_b_d;
    logic [DATA_W-1:0]   alu_out_q, alu_out_d;
    logic [DATA_W-1:0]   rf_q [RF_DEPTH];
    logic [DATA_W-1:0]   rf_d [RF_DEPTH];
    logic [DATA_W-1:0]   dmem [DMEM_DEPTH];
    logic [DATA_W-1:0]   dmem_rd_q;

    logic [DATA_W-1:0]   rf_a, rf_b, alu_res, rf_wdat;
    logic                rf_we, dmem_we, flags_we;

    // Combinational register-file reads for the latched source addresses.
    assign rf_a = rf_q[raddr_a_q];
    assign rf_b = rf_q[raddr_b_q];

    // ALU on live RF operands; wraps modulo 2^DATA_W.
    always_comb begin
        alu_res = '0;
        case (sel_q)
            3'd0:    alu_res = rf_a;
            3'd1:    alu_res = rf_a + rf_b;
            3'd2:    alu_res = rf_a - rf_b;
            3'd3:    alu_res = rf_a & rf_b;
            3'd4:    alu_res = rf_a | rf_b;
            3'd5:    alu_res = rf_a ^ rf_b;
            3'd6:    alu_res = ~rf_a;
            default: alu_res = '0;
        endcase
    end

    // Sequencer: command capture, operand/result latching and write enables.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        sel_d      = sel_q;
        daddr_d    = daddr_q;
        waddr_d    = waddr_q;
        raddr_a_d  = raddr_a_q;
        raddr_b_d  = raddr_b_q;
        alu_in_a_d = alu_in_a_q;
        alu_in_b_d = alu_in_b_q;
        alu_out_d  = alu_out_q;
        rf_we      = 1'b0;
        rf_wdat    = alu_res;
        dmem_we    = 1'b0;
        flags_we   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    op_d      = bus.Op;
                    sel_d     = bus.ALUSelect;
                    daddr_d   = bus.DAddr;
                    waddr_d   = bus.WriteAddr;
                    raddr_a_d = bus.ReadAddrA;
                    raddr_b_d = bus.ReadAddrB;
                    state_d   = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_in_a_d = rf_a;
                alu_in_b_d = rf_b;
                case (op_q)
                    OP_ALU: begin
                        alu_out_d = alu_res;
                        rf_we     = 1'b1;
                        flags_we  = 1'b1;
                        state_d   = S_DONE;
                    end
                    OP_STORE: begin
                        dmem_we = 1'b1;
                        state_d = S_DONE;
                    end
                    OP_LOAD: state_d = S_MEMRD;
                    default: state_d = S_DONE;
                endcase
            end
            S_MEMRD: begin
                rf_we   = 1'b1;
                rf_wdat = dmem_rd_q;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Next register-file image: single write port.
    always_comb begin
        rf_d = rf_q;
        if (rf_we) begin
            rf_d[waddr_q] = rf_wdat;
        end
    end

    // Control, operand and register-file state; reset clears the RF and aborts any write.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            sel_q      <= '0;
            daddr_q    <= '0;
            waddr_q    <= '0;
            raddr_a_q  <= '0;
            raddr_b_q  <= '0;
            alu_in_a_q <= '0;
            alu_in_b_q <= '0;
            alu_out_q  <= '0;
            rf_q       <= '{default: '0};
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            sel_q      <= sel_d;
            daddr_q    <= daddr_d;
            waddr_q    <= waddr_d;
            raddr_a_q  <= raddr_a_d;
            raddr_b_q  <= raddr_b_d;
            alu_in_a_q <= alu_in_a_d;
            alu_in_b_q <= alu_in_b_d;
            alu_out_q  <= alu_out_d;
            rf_q       <= rf_d;
        end
    end

    // Data memory: synchronous read every cycle, so the word is ready in MEMRD; contents survive reset.
    always_ff @(posedge Clk) begin
        if (!Reset && dmem_we) begin
            dmem[daddr_q] <= rf_a;
        end
        dmem_rd_q <= dmem[daddr_q];
    end

`ifdef DATAPATH_GEN_FLAGS_EN
    logic zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d;

    // Status flags derived from the ALU result; only ADD/SUB produce carry and overflow.
    always_comb begin
        zero_d  = zero_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        if (flags_we) begin
            zero_d  = (alu_res == '0);
            carry_d = 1'b0;
            ovf_d   = 1'b0;
            if (sel_q == 3'd1) begin
                // Unsigned wrap of a sum shows up as a result smaller than an operand.
                carry_d = (alu_res < rf_a);
                ovf_d   = (rf_a[DATA_W-1] == rf_b[DATA_W-1]) &&
                          (alu_res[DATA_W-1] != rf_a[DATA_W-1]);
            end else if (sel_q == 3'd2) begin
                carry_d = (rf_a < rf_b);
                ovf_d   = (rf_a[DATA_W-1] != rf_b[DATA_W-1]) &&
                          (alu_res[DATA_W-1] != rf_a[DATA_W-1]);
            end
        end
    end

    // Flag registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            zero_q  <= zero_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.Zero     = zero_q;
    assign bus.Carry    = carry_q;
    assign bus.Overflow = ovf_q;
`else
    assign bus.Zero     = 1'b0;
    assign bus.Carry    = 1'b0;
    assign bus.Overflow = 1'b0;

    logic unused_flags;
    assign unused_flags = flags_we;
`endif

    assign bus.Busy   = (state_q == S_EXEC) || (state_q == S_MEMRD);
    assign bus.Done   = (state_q == S_DONE);
    assign bus.ALUinA = alu_in_a_q;
    assign bus.ALUinB = alu_in_b_q;
    assign bus.ALUout = alu_out_q;

endmodule

// File: tb/tb_datapath_gen.sv
// Scoreboard bench for datapath_gen: directed commands push expected results, a monitor checks on Done.
// Latency: checks Done at 2 edges (ALU/STORE) or 3 (LOAD) after accept and Busy length.
// Backpressure: covers Start held through a command and reset while a LOAD is in MEMRD.
module tb_datapath_gen;
    logic Clk = 1'b0;
    logic Reset = 1'b1;

    datapath_gen_if #(.DATA_W(16), .RF_DEPTH(16), .DMEM_DEPTH(256)) bus ();

    datapath_gen #(.DATA_W(16), .RF_DEPTH(16), .DMEM_DEPTH(256)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] o;
        logic        z;
        logic        c;
        logic        v;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    int tests    = 0;
    int fails    = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int busy_cnt = 0;
    int pushed   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge Clk) cyc <= cyc + 1;

    // Monitor: samples 1 time unit after each rising edge and scores every Done.
    initial begin
        exp_t e;
        logic ez, ec, ev;
        forever begin
            @(posedge Clk);
            #1;
            if (Reset) begin
                busy_cnt = 0;
            end else begin
                if (bus.Busy) busy_cnt++;
                if (bus.Done) begin
                    done_cnt++;
                    if (q.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = q.pop_front();
`ifdef DATAPATH_GEN_FLAGS_EN
                        ez = e.z; ec = e.c; ev = e.v;
`else
                        ez = 1'b0; ec = 1'b0; ev = 1'b0;
`endif
                        chk("ALUinA",   32'(bus.ALUinA), 32'(e.a));
                        chk("ALUinB",   32'(bus.ALUinB), 32'(e.b));
                        chk("ALUout",   32'(bus.ALUout), 32'(e.o));
                        chk("Zero",     32'(bus.Zero), 32'(ez));
                        chk("Carry",    32'(bus.Carry), 32'(ec));
                        chk("Overflow", 32'(bus.Overflow), 32'(ev));
                        chk("latency",  32'(cyc - e.acc + 1), 32'(e.lat));
                        chk("busy_len", 32'(busy_cnt), 32'(e.lat - 1));
                        chk("busy_in_done", 32'(bus.Busy), 32'd0);
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    // Issue one command from IDLE, push its expected result, and wait (bounded) for Done.
    task automatic issue(input logic [1:0] op, input logic [2:0] sel, input logic [7:0] da,
                         input logic [3:0] wa, input logic [3:0] ra, input logic [3:0] rb,
                         input logic [15:0] ea, input logic [15:0] eb, input logic [15:0] eo,
                         input logic ez, input logic ec, input logic ev, input bit hold);
        exp_t e;
        int seen;
        @(negedge Clk);
        bus.Op        = op;
        bus.ALUSelect = sel;
        bus.DAddr     = da;
        bus.WriteAddr = wa;
        bus.ReadAddrA = ra;
        bus.ReadAddrB = rb;
        bus.Start     = 1'b1;
        e.a = ea; e.b = eb; e.o = eo; e.z = ez; e.c = ec; e.v = ev;
        e.lat = (op == 2'd0) ? 3 : 2;
        e.acc = cyc + 1;
        q.push_back(e);
        pushed++;
        seen = done_cnt;
        @(negedge Clk);
        chk("busy_after_accept", 32'(bus.Busy), 32'd1);
        if (!hold) bus.Start = 1'b0;
        // Inputs are don't-care after accept; scramble them.
        bus.DAddr     = ~da;
        bus.WriteAddr = ~wa;
        bus.ReadAddrA = ~ra;
        bus.ReadAddrB = ~rb;
        bus.ALUSelect = ~sel;
        for (int i = 0; i < 10 && done_cnt == seen; i++) @(negedge Clk);
        chk("done_seen", 32'(done_cnt - seen), 32'd1);
        @(negedge Clk);
        bus.Start = 1'b0;
        if (hold) begin
            @(negedge Clk);
            chk("no_reaccept_busy", 32'(bus.Busy), 32'd0);
            @(negedge Clk);
            chk("no_reaccept_done", 32'(done_cnt - seen), 32'd1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        bus.Start = 1'b0; bus.Op = 2'd3; bus.ALUSelect = 3'd0; bus.DAddr = 8'd0;
        bus.WriteAddr = 4'd0; bus.ReadAddrA = 4'd0; bus.ReadAddrB = 4'd0;
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        chk("rst_busy",   32'(bus.Busy), 32'd0);
        chk("rst_done",   32'(bus.Done), 32'd0);
        chk("rst_aluout", 32'(bus.ALUout), 32'd0);
        chk("rst_alu_a",  32'(bus.ALUinA), 32'd0);
        chk("rst_alu_b",  32'(bus.ALUinB), 32'd0);
        chk("rst_flags",  32'({bus.Zero, bus.Carry, bus.Overflow}), 32'd0);
        Reset = 1'b0;

        //     op    sel   da      wa    ra    rb    A         B         out       Z     C     V     hold
        issue(2'd2, 3'd6, 8'd0,   4'd1, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0, 0);
        issue(2'd2, 3'd1, 8'd0,   4'd2, 4'd1, 4'd1, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0, 1'b1, 1'b0, 0);
        issue(2'd2, 3'd2, 8'd0,   4'd3, 4'd1, 4'd1, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 0);
        issue(2'd2, 3'd2, 8'd0,   4'd4, 4'd0, 4'd1, 16'h0000, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0, 0);
        issue(2'd1, 3'd0, 8'd9,   4'd0, 4'd2, 4'd0, 16'hFFFE, 16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0, 0);
        issue(2'd0, 3'd0, 8'd9,   4'd5, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0, 0);
        issue(2'd2, 3'd0, 8'd0,   4'd7, 4'd5, 4'd0, 16'hFFFE, 16'h0000, 16'hFFFE, 1'b0, 1'b0, 1'b0, 0);
        issue(2'd2, 3'd3, 8'd0,   4'd8, 4'd2, 4'd4, 16'hFFFE, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 0);
        issue(2'd2, 3'd4, 8'd0,   4'd9, 4'd2, 4'd4, 16'hFFFE, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0, 0);
        issue(2'd2, 3'd7, 8'd0,  4'd10, 4'd1, 4'd1, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 0);
        issue(2'd1, 3'd0, 8'd255, 4'd0, 4'd1, 4'd0, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 0);
        issue(2'd0, 3'd0, 8'd255,4'd15, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1);
        issue(2'd2, 3'd5, 8'd0,  4'd14, 4'd15,4'd2, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0, 1'b0, 1'b0, 0);
        issue(2'd2, 3'd1, 8'd0,  4'd11, 4'd4, 4'd1, 16'h0001, 16'hFFFF, 16'h0000, 1'b1, 1'b1, 1'b0, 0);
        issue(2'd3, 3'd1, 8'd0,  4'd12, 4'd7, 4'd9, 16'hFFFE, 16'hFFFF, 16'h0000, 1'b1, 1'b1, 1'b0, 0);

        // LOAD D[9] into R6, aborted by reset while in MEMRD.
        seen = done_cnt;
        @(negedge Clk);
        bus.Op = 2'd0; bus.DAddr = 8'd9; bus.WriteAddr = 4'd6;
        bus.ReadAddrA = 4'd0; bus.ReadAddrB = 4'd0; bus.Start = 1'b1;
        @(negedge Clk);
        bus.Start = 1'b0;
        chk("abort_exec_busy", 32'(bus.Busy), 32'd1);
        @(negedge Clk);
        chk("abort_memrd_busy", 32'(bus.Busy), 32'd1);
        Reset = 1'b1;
        @(negedge Clk);
        chk("abort_busy",   32'(bus.Busy), 32'd0);
        chk("abort_done",   32'(bus.Done), 32'd0);
        chk("abort_aluout", 32'(bus.ALUout), 32'd0);
        chk("abort_alu_a",  32'(bus.ALUinA), 32'd0);
        Reset = 1'b0;
        @(negedge Clk);
        chk("abort_no_done", 32'(done_cnt - seen), 32'd0);

        // R6 never written, R15 cleared; D[9] survives reset.
        issue(2'd2, 3'd1, 8'd0,  4'd12, 4'd6, 4'd15,16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 0);
        issue(2'd0, 3'd0, 8'd9,   4'd2, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 0);
        issue(2'd2, 3'd0, 8'd0,   4'd3, 4'd2, 4'd0, 16'hFFFE, 16'h0000, 16'hFFFE, 1'b0, 1'b0, 1'b0, 0);

        repeat (3) @(negedge Clk);
        chk("queue_empty", 32'(q.size()), 32'd0);
        chk("done_total",  32'(done_cnt), 32'(pushed));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
